// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - memory-mapped GPIO port with direction control, atomic output ops and edge interrupts
module gpio_port #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_FF00,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      address,
    input  logic [31:0]      writedata,
    input  logic             wenable,
    input  logic             renable,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam logic [5:0] OFF_OUT  = 6'h00;
    localparam logic [5:0] OFF_DIR  = 6'h01;
    localparam logic [5:0] OFF_IN   = 6'h02;
    localparam logic [5:0] OFF_SET  = 6'h03;
    localparam logic [5:0] OFF_CLR  = 6'h04;
    localparam logic [5:0] OFF_TGL  = 6'h05;
    localparam logic [5:0] OFF_RISE = 6'h06;
    localparam logic [5:0] OFF_FALL = 6'h07;
    localparam logic [5:0] OFF_PEND = 6'h08;
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, pend_q;
    logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q, prev_q;
    logic [2:0]       warm_cnt;

    logic             hit, wr, rd;
    logic [5:0]       off;
    logic [WIDTH-1:0] wdata, w1c_mask, rise, fall, edge_set, out_next;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign hit   = (address[31:8] == ADDR_BASE[31:8]);
    assign off   = address[7:2];
    assign wr    = wenable && hit;
    assign rd    = renable && hit;
    assign wdata = writedata[WIDTH-1:0];
    assign unused_bits = ^{address[1:0], writedata};

    assign sync_q = sync_chain[SYNC_STAGES-1];
    assign rise   = sync_q & ~prev_q;
    assign fall   = ~sync_q & prev_q;

    // Edges are masked until the synchroniser has flushed its reset zeros, so
    // pins already high at reset do not look like rising edges.
    assign edge_set = (warm_cnt == WARM_DONE) ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
    assign w1c_mask = (wr && off == OFF_PEND) ? wdata : '0;

    always_comb begin
        out_next = out_q;
        if (wr) begin
            case (off)
                OFF_OUT: out_next = wdata;
                OFF_SET: out_next = out_q | wdata;
                OFF_CLR: out_next = out_q & ~wdata;
                OFF_TGL: out_next = out_q ^ wdata;
                default: out_next = out_q;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_OUT:  rdata[WIDTH-1:0] = out_q;
            OFF_DIR:  rdata[WIDTH-1:0] = dir_q;
            OFF_IN:   rdata[WIDTH-1:0] = sync_q;
            OFF_RISE: rdata[WIDTH-1:0] = rise_en_q;
            OFF_FALL: rdata[WIDTH-1:0] = fall_en_q;
            OFF_PEND: rdata[WIDTH-1:0] = pend_q;
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
            warm_cnt  <= '0;
            readdata  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= '0;
        end else begin
            sync_chain[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
            prev_q <= sync_q;
            if (warm_cnt != WARM_DONE) warm_cnt <= warm_cnt + 3'd1;

            out_q <= out_next;
            if (wr && off == OFF_DIR)  dir_q     <= wdata;
            if (wr && off == OFF_RISE) rise_en_q <= wdata;
            if (wr && off == OFF_FALL) fall_en_q <= wdata;
            pend_q <= (pend_q & ~w1c_mask) | edge_set;

            readdata <= rd ? rdata : 32'h0;
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |pend_q;
endmodule

// File: tb/tb_gpio_port.sv
// tb/tb_gpio_port.sv - directed and randomised checks of gpio_port against a pin-history model
module tb_gpio_port;
    localparam int          S    = 2;
    localparam logic [31:0] BASE = 32'h0000_FF00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = 32'h0, writedata = 32'h0;
    logic        wenable = 1'b0, renable = 1'b0;
    logic [31:0] readdata;
    logic [7:0]  gpio_in = 8'h00, gpio_out, gpio_oe;
    logic        irq;

    logic [31:0] address5 = BASE, writedata5 = 32'h0;
    logic        wenable5 = 1'b0, renable5 = 1'b0;
    logic [31:0] readdata5;
    logic [4:0]  gpio_in5 = 5'h00, gpio_out5, gpio_oe5;
    logic        irq5;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: registers plus the history of pin values sampled at each edge.
    logic [7:0]  m_out, m_dir, m_re, m_fe, m_pend;
    logic [31:0] m_rd;
    logic [7:0]  h [0:S];
    int          k;

    gpio_port #(.WIDTH(8), .ADDR_BASE(BASE), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .address(address), .writedata(writedata),
        .wenable(wenable), .renable(renable), .readdata(readdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_port #(.WIDTH(5), .ADDR_BASE(BASE), .SYNC_STAGES(S)) dut5 (
        .clk(clk), .reset(reset), .address(address5), .writedata(writedata5),
        .wenable(wenable5), .renable(renable5), .readdata(readdata5),
        .gpio_in(gpio_in5), .gpio_out(gpio_out5), .gpio_oe(gpio_oe5), .irq(irq5)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic [7:0] rise, fall, newp, w1c, wd;
        logic       hit;
        logic [5:0] off;
        @(posedge clk);
        if (reset) begin
            m_out = 0; m_dir = 0; m_re = 0; m_fe = 0; m_pend = 0; m_rd = 0; k = 0;
            for (int i = 0; i <= S; i++) h[i] = 8'h00;
        end else begin
            k++;
            hit  = (address[31:8] == BASE[31:8]);
            off  = address[7:2];
            wd   = writedata[7:0];
            // h[S-1] is the pin value from S edges ago, h[S] the one before it.
            rise = h[S-1] & ~h[S];
            fall = ~h[S-1] & h[S];
            newp = (k > S + 1) ? ((rise & m_re) | (fall & m_fe)) : 8'h00;
            m_rd = 32'h0;
            if (renable && hit) begin
                case (off)
                    6'd0: m_rd = {24'h0, m_out};
                    6'd1: m_rd = {24'h0, m_dir};
                    6'd2: m_rd = {24'h0, h[S-1]};
                    6'd6: m_rd = {24'h0, m_re};
                    6'd7: m_rd = {24'h0, m_fe};
                    6'd8: m_rd = {24'h0, m_pend};
                    default: m_rd = 32'h0;
                endcase
            end
            w1c = 8'h00;
            if (wenable && hit) begin
                case (off)
                    6'd0: m_out = wd;
                    6'd1: m_dir = wd;
                    6'd3: m_out = m_out | wd;
                    6'd4: m_out = m_out & ~wd;
                    6'd5: m_out = m_out ^ wd;
                    6'd6: m_re = wd;
                    6'd7: m_fe = wd;
                    6'd8: w1c = wd;
                    default: ;
                endcase
            end
            m_pend = (m_pend & ~w1c) | newp;
            for (int i = S; i > 0; i--) h[i] = h[i-1];
            h[0] = gpio_in;
        end
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        address = BASE + off; writedata = d; wenable = 1'b1;
        tick();
        wenable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off);
        address = BASE + off; renable = 1'b1;
        tick();
        renable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; gpio_in = 8'hFF;
        idle(3);
        n_checks++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h expected 00", gpio_out); end
        n_checks++; if (gpio_oe !== 8'h00) begin n_fail++; $display("FAIL reset_oe: got %h expected 00", gpio_oe); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
        reset = 1'b0;
        wr(32'h18, 32'hFF);
        idle(10);
        rd(32'h20);
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL warmup_pend: got %h expected 0", readdata); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL warmup_irq: got %b expected 0", irq); end
    endtask

    task automatic test_atomic();
        wr(32'h00, 32'hA5);
        n_checks++; if (gpio_out !== 8'hA5) begin n_fail++; $display("FAIL out_write: got %h expected a5", gpio_out); end
        wr(32'h0C, 32'h0F);
        n_checks++; if (gpio_out !== 8'hAF) begin n_fail++; $display("FAIL out_set: got %h expected af", gpio_out); end
        wr(32'h10, 32'h81);
        n_checks++; if (gpio_out !== 8'h2E) begin n_fail++; $display("FAIL out_clr: got %h expected 2e", gpio_out); end
        wr(32'h14, 32'hFF);
        n_checks++; if (gpio_out !== 8'hD1) begin n_fail++; $display("FAIL out_tgl: got %h expected d1", gpio_out); end
        rd(32'h00);
        n_checks++; if (readdata !== 32'hD1) begin n_fail++; $display("FAIL out_read: got %h expected d1", readdata); end
        idle(1);
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL readdata_idle: got %h expected 0", readdata); end
        rd(32'h0C);
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL set_reads_zero: got %h expected 0", readdata); end
    endtask

    task automatic test_edge();
        wr(32'h18, 32'h01);
        wr(32'h1C, 32'h02);
        gpio_in = 8'h02;
        idle(5);
        wr(32'h20, 32'hFF);
        gpio_in = 8'h01;
        idle(2);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_early_irq: got %b expected 0", irq); end
        idle(1);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL edge_irq: got %b expected 1", irq); end
        rd(32'h20);
        n_checks++; if (readdata !== 32'h03) begin n_fail++; $display("FAIL edge_pend: got %h expected 03", readdata); end
        gpio_in = 8'h05;
        idle(5);
        rd(32'h20);
        n_checks++; if (readdata !== 32'h03) begin n_fail++; $display("FAIL disabled_pin_pend: got %h expected 03", readdata); end
    endtask

    task automatic test_w1c_collision();
        wr(32'h20, 32'h02);
        rd(32'h20);
        n_checks++; if (readdata !== 32'h01) begin n_fail++; $display("FAIL w1c_partial: got %h expected 01", readdata); end
        gpio_in = 8'h04;
        idle(5);
        gpio_in = 8'h05;
        idle(2);
        wr(32'h20, 32'h01);
        rd(32'h20);
        n_checks++; if (readdata !== 32'h01) begin n_fail++; $display("FAIL w1c_collision: got %h expected 01", readdata); end
        wr(32'h20, 32'h01);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_clear_irq: got %b expected 0", irq); end
        rd(32'h20);
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL w1c_clear_pend: got %h expected 0", readdata); end
    endtask

    task automatic test_decode_width();
        wr(32'h00, 32'hFFFF_FFFF);
        rd(32'h00);
        n_checks++; if (readdata !== 32'h0000_00FF) begin n_fail++; $display("FAIL width8_read: got %h expected ff", readdata); end
        rd(32'h3C);
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL undef_read: got %h expected 0", readdata); end
        wr(32'h100, 32'h12);
        n_checks++; if (gpio_out !== 8'hFF) begin n_fail++; $display("FAIL miss_write: got %h expected ff", gpio_out); end
        wr(32'h24, 32'h0);
        n_checks++; if (gpio_out !== 8'hFF) begin n_fail++; $display("FAIL undef_write: got %h expected ff", gpio_out); end
        rd(32'h100);
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL miss_read: got %h expected 0", readdata); end
        address5 = BASE + 32'h1; writedata5 = 32'hFFFF_FFFF; wenable5 = 1'b1;
        tick();
        wenable5 = 1'b0; renable5 = 1'b1;
        tick();
        renable5 = 1'b0;
        n_checks++; if (readdata5 !== 32'h0000_001F) begin n_fail++; $display("FAIL width5_read: got %h expected 1f", readdata5); end
    endtask

    task automatic test_mid_reset();
        wr(32'h18, 32'hFF);
        wr(32'h1C, 32'hFF);
        gpio_in = 8'h00;
        idle(5);
        gpio_in = 8'hFF;
        idle(5);
        rd(32'h20);
        n_checks++; if (readdata !== 32'hFF) begin n_fail++; $display("FAIL pend_all: got %h expected ff", readdata); end
        wr(32'h00, 32'h55);
        wr(32'h04, 32'h3C);
        n_checks++; if (gpio_oe !== 8'h3C) begin n_fail++; $display("FAIL dir_write: got %h expected 3c", gpio_oe); end
        reset = 1'b1; gpio_in = 8'h00;
        address = BASE + 32'h20; renable = 1'b1;
        tick();
        renable = 1'b0;
        n_checks++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL midreset_out: got %h expected 00", gpio_out); end
        n_checks++; if (gpio_oe !== 8'h00) begin n_fail++; $display("FAIL midreset_oe: got %h expected 00", gpio_oe); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b expected 0", irq); end
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL midreset_readdata: got %h expected 0", readdata); end
        reset = 1'b0; gpio_in = 8'hFF;
        wr(32'h18, 32'hFF);
        idle(10);
        rd(32'h20);
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL midreset_warmup_pend: got %h expected 0", readdata); end
        rd(32'h08);
        n_checks++; if (readdata !== 32'hFF) begin n_fail++; $display("FAIL in_read: got %h expected ff", readdata); end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            gpio_in   = gpio_in ^ 8'($urandom & $urandom & $urandom);
            r         = $urandom_range(0, 15);
            if (r < 12)      address = BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
            else if (r < 14) address = BASE + 32'h100 + 32'($urandom_range(0, 63));
            else             address = $urandom;
            writedata = $urandom;
            wenable   = 1'($urandom_range(0, 1));
            renable   = 1'($urandom_range(0, 1));
            tick();
            n_checks++; if (gpio_out !== m_out) begin n_fail++; $display("FAIL rand_out cycle %0d: got %h expected %h", c, gpio_out, m_out); end
            n_checks++; if (gpio_oe !== m_dir) begin n_fail++; $display("FAIL rand_oe cycle %0d: got %h expected %h", c, gpio_oe, m_dir); end
            n_checks++; if (irq !== (m_pend != 8'h00)) begin n_fail++; $display("FAIL rand_irq cycle %0d: got %b expected %b", c, irq, m_pend != 8'h00); end
            n_checks++; if (readdata !== m_rd) begin n_fail++; $display("FAIL rand_readdata cycle %0d: got %h expected %h", c, readdata, m_rd); end
        end
        wenable = 1'b0; renable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_atomic();
        test_edge();
        test_w1c_collision();
        test_decode_width();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
